keypad_supervisor: RTL and testbench



---
 rtl/keypad_pkg.sv | 33 +++
 rtl/btn_edge_pulse.sv | 32 +++
 rtl/keypad_supervisor.sv | 203 ++++++++++++++++++++
 tb/tb_keypad_supervisor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package  : keypad_pkg
// Brief    : Supervisor state type, keypad state codes and counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_OPEN_HOLD = 3'd2,
    S_LOCKOUT   = 3'd3,
    S_ALARM     = 3'd4
  } sup_state_t;

  // Keypad FSM state codes, used by monitors watching the keypad
  localparam logic [2:0] KP_DIG0 = 3'b000;
  localparam logic [2:0] KP_DIG1 = 3'b001;
  localparam logic [2:0] KP_DIG2 = 3'b011;
  localparam logic [2:0] KP_DIG3 = 3'b010;
  localparam logic [2:0] KP_SECV = 3'b100;
  localparam logic [2:0] KP_RSTS = 3'b101;
  localparam logic [2:0] KP_OFF  = 3'b111;
  localparam logic [2:0] KP_OPEN = 3'b110;

  // Bits needed to hold 0..n-1, never less than one
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge_pulse
// Brief    : Flags a 0->1 transition of a synchronous button level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign o_rise = i_raw & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/keypad_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : keypad_supervisor
// Brief    : Button strobes, fail count / lockout, door hold and alarm latch
//            for the passcode keypad. Optional macro: ENTRY_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_supervisor
  import keypad_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ZRAW,
  input  logic                          ORAW,
  input  logic                          ACK,
  input  logic                          KRSTO,
  input  logic                          KULCK,
  input  logic                          KSECV,
  output logic                          ZBUT,
  output logic                          OBUT,
  output logic                          ENBL,
  output logic                          DOOR,
  output logic                          LKOUT,
  output logic                          ALRM,
  output logic [cnt_w(MAX_FAILS+1)-1:0] FCNT
);

  localparam int c_fw = cnt_w(MAX_FAILS + 1);
  localparam int c_lw = cnt_w(LOCKOUT_CYCLES);
  localparam int c_ow = cnt_w(OPEN_CYCLES);
  localparam logic [c_fw-1:0] c_max_fails = c_fw'(MAX_FAILS);
  localparam logic [c_lw-1:0] c_lock_load = c_lw'(LOCKOUT_CYCLES - 1);
  localparam logic [c_ow-1:0] c_open_load = c_ow'(OPEN_CYCLES - 1);

  if (MAX_FAILS < 1 || LOCKOUT_CYCLES < 2 || OPEN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("keypad_supervisor: illegal parameter value");
  end

  sup_state_t      state_q, state_d;
  logic            enbl_q, enbl_d;
  logic            door_q, door_d;
  logic            lkout_q, lkout_d;
  logic            alrm_q, alrm_d;
  logic            zbut_q, zbut_d;
  logic            obut_q, obut_d;
  logic [c_fw-1:0] fcnt_q, fcnt_d;
  logic [c_lw-1:0] lock_tmr_q, lock_tmr_d;
  logic [c_ow-1:0] open_tmr_q, open_tmr_d;
  logic [c_fw-1:0] w_fail_next;
  logic            w_zrise, w_orise, w_issue;

`ifdef ENTRY_TIMEOUT_EN
  localparam int c_tw = cnt_w(TIMEOUT_CYCLES);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYCLES - 1);
  logic [c_tw-1:0] idle_q, idle_d;
`endif

  btn_edge_pulse u_zero_edge (.clk(CLK), .rst(RST), .i_raw(ZRAW), .o_rise(w_zrise));
  btn_edge_pulse u_one_edge  (.clk(CLK), .rst(RST), .i_raw(ORAW), .o_rise(w_orise));

  // Coincident rising edges are ambiguous and both dropped
  assign w_issue     = enbl_q & (w_zrise ^ w_orise);
  assign w_fail_next = (fcnt_q == c_max_fails) ? fcnt_q : fcnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    enbl_d     = enbl_q;
    door_d     = door_q;
    lkout_d    = lkout_q;
    alrm_d     = alrm_q;
    fcnt_d     = fcnt_q;
    lock_tmr_d = lock_tmr_q;
    open_tmr_d = open_tmr_q;
    zbut_d     = 1'b0;
    obut_d     = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    idle_d     = '0;
`endif
    if (KSECV) begin
      state_d    = S_ALARM;
      alrm_d     = 1'b1;
      enbl_d     = 1'b0;
      door_d     = 1'b0;
      lkout_d    = 1'b0;
      lock_tmr_d = '0;
      open_tmr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          enbl_d = 1'b1;
          if (w_issue) begin
            zbut_d  = w_zrise;
            obut_d  = w_orise;
            state_d = S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (KULCK) begin
            state_d    = S_OPEN_HOLD;
            fcnt_d     = '0;
            door_d     = 1'b1;
            open_tmr_d = c_open_load;
          end else if (KRSTO) begin
            fcnt_d = w_fail_next;
            if (w_fail_next == c_max_fails) begin
              state_d    = S_LOCKOUT;
              enbl_d     = 1'b0;
              lkout_d    = 1'b1;
              lock_tmr_d = c_lock_load;
            end else begin
              state_d = S_IDLE;
            end
          end else if (w_issue) begin
            zbut_d = w_zrise;
            obut_d = w_orise;
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (idle_q == c_tmo_last) begin
            // One low cycle of ENBL forces the keypad back to its off state
            state_d = S_IDLE;
            enbl_d  = 1'b0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end
        S_OPEN_HOLD: begin
          if (open_tmr_q == '0) begin
            state_d = S_IDLE;
            door_d  = 1'b0;
          end else begin
            open_tmr_d = open_tmr_q - 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (lock_tmr_q == '0) begin
            state_d = S_IDLE;
            enbl_d  = 1'b1;
            lkout_d = 1'b0;
            fcnt_d  = '0;
          end else begin
            lock_tmr_d = lock_tmr_q - 1'b1;
          end
        end
        S_ALARM: begin
          if (ACK) begin
            state_d = S_IDLE;
            enbl_d  = 1'b1;
            alrm_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      enbl_q     <= 1'b0;
      door_q     <= 1'b0;
      lkout_q    <= 1'b0;
      alrm_q     <= 1'b0;
      zbut_q     <= 1'b0;
      obut_q     <= 1'b0;
      fcnt_q     <= '0;
      lock_tmr_q <= '0;
      open_tmr_q <= '0;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      enbl_q     <= enbl_d;
      door_q     <= door_d;
      lkout_q    <= lkout_d;
      alrm_q     <= alrm_d;
      zbut_q     <= zbut_d;
      obut_q     <= obut_d;
      fcnt_q     <= fcnt_d;
      lock_tmr_q <= lock_tmr_d;
      open_tmr_q <= open_tmr_d;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign ZBUT  = zbut_q;
  assign OBUT  = obut_q;
  assign ENBL  = enbl_q;
  assign DOOR  = door_q;
  assign LKOUT = lkout_q;
  assign ALRM  = alrm_q;
  assign FCNT  = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_supervisor
// Brief    : Directed and random stimulus against a behavioural supervisor
//            model, with a simple 1000-passcode keypad model in the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_supervisor;
  import keypad_pkg::*;

  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int OPEN_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int FW             = cnt_w(MAX_FAILS + 1);
`ifdef ENTRY_TIMEOUT_EN
  localparam int TMO_LOW = 1;
`else
  localparam int TMO_LOW = 0;
`endif

  logic CLK = 1'b0, RST = 1'b0;
  logic ZRAW = 1'b0, ORAW = 1'b0, ACK = 1'b0;
  logic KRSTO = 1'b0, KULCK = 1'b0, KSECV = 1'b0;
  logic ZBUT, OBUT, ENBL, DOOR, LKOUT, ALRM;
  logic [FW-1:0] FCNT;

  int n_checks = 0, n_pass = 0;
  int n_strobe = 0, n_enlow = 0, n_door = 0;

  // supervisor reference model
  string m_mode;
  bit    m_pz, m_po;
  int    m_left, m_quiet, m_fails;
  bit    e_zbut, e_obut, e_enbl, e_door, e_lk, e_alrm;

  // keypad model
  logic [2:0] kp_code;
  int         kp_stage;
  bit         r_z = 1'b0, r_o = 1'b0;

  keypad_supervisor #(
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .OPEN_CYCLES(OPEN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .ZRAW(ZRAW), .ORAW(ORAW), .ACK(ACK),
    .KRSTO(KRSTO), .KULCK(KULCK), .KSECV(KSECV),
    .ZBUT(ZBUT), .OBUT(OBUT), .ENBL(ENBL), .DOOR(DOOR),
    .LKOUT(LKOUT), .ALRM(ALRM), .FCNT(FCNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = "idle"; m_pz = 0; m_po = 0; m_left = 0; m_quiet = 0; m_fails = 0;
    e_zbut = 0; e_obut = 0; e_enbl = 0; e_door = 0; e_lk = 0; e_alrm = 0;
  endtask

  task automatic kp_reset();
    kp_code = KP_OFF; kp_stage = 0;
  endtask

  task automatic model_step(input bit z, input bit o, input bit a, input bit s,
                            input bit krsto, input bit kulck);
    bit zr, orr, go;
    zr  = z && !m_pz;
    orr = o && !m_po;
    m_pz = z; m_po = o;
    go = e_enbl && (zr != orr) && (m_mode == "idle" || m_mode == "entry");
    e_zbut = 0; e_obut = 0;
    if (s) begin
      m_mode = "alarm"; e_alrm = 1; e_enbl = 0; e_door = 0; e_lk = 0; m_left = 0;
    end else if (m_mode == "idle") begin
      if (go) begin e_zbut = zr; e_obut = orr; m_mode = "entry"; m_quiet = 0; end
      e_enbl = 1;
    end else if (m_mode == "entry") begin
      if (kulck) begin
        m_mode = "open"; m_fails = 0; e_door = 1; m_left = OPEN_CYCLES;
      end else if (krsto) begin
        m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
        if (m_fails == MAX_FAILS) begin
          m_mode = "lock"; e_enbl = 0; e_lk = 1; m_left = LOCKOUT_CYCLES;
        end else m_mode = "idle";
      end else if (go) begin
        e_zbut = zr; e_obut = orr; m_quiet = 0;
      end else begin
        m_quiet++;
`ifdef ENTRY_TIMEOUT_EN
        if (m_quiet == TIMEOUT_CYCLES) begin m_mode = "idle"; e_enbl = 0; end
`endif
      end
    end else if (m_mode == "open") begin
      m_left--;
      if (m_left == 0) begin m_mode = "idle"; e_door = 0; end
    end else if (m_mode == "lock") begin
      m_left--;
      if (m_left == 0) begin m_mode = "idle"; e_enbl = 1; e_lk = 0; m_fails = 0; end
    end else if (m_mode == "alarm") begin
      if (a) begin m_mode = "idle"; e_enbl = 1; e_alrm = 0; end
    end
  endtask

  // Passcode 1000; a wrong digit shows RSTS for one cycle, unlock shows OPEN then RSTS
  task automatic kp_step(input bit zb, input bit ob, input bit en);
    logic [2:0] codes [4];
    int want;
    codes[0] = KP_DIG0; codes[1] = KP_DIG1; codes[2] = KP_DIG2; codes[3] = KP_DIG3;
    if (!en) begin
      kp_code = KP_OFF; kp_stage = 0;
    end else if (kp_code == KP_OFF || kp_code == KP_RSTS) begin
      kp_code = KP_DIG0; kp_stage = 0;
    end else if (kp_code == KP_OPEN) begin
      kp_code = KP_RSTS;
    end else if (zb || ob) begin
      want = (kp_stage == 0) ? 1 : 0;
      if (int'(ob) == want) begin
        if (kp_stage == 3) kp_code = KP_OPEN;
        else begin kp_stage++; kp_code = codes[kp_stage]; end
      end else kp_code = KP_RSTS;
    end
  endtask

  task automatic cycle(input bit z, input bit o, input bit a, input bit s);
    bit pz, po, pe;
    logic [FW-1:0] ef;
    ZRAW = z; ORAW = o; ACK = a; KSECV = s;
    KRSTO = (kp_code == KP_RSTS);
    KULCK = (kp_code == KP_OPEN);
    pz = ZBUT; po = OBUT; pe = ENBL;
    @(posedge CLK);
    model_step(z, o, a, s, KRSTO, KULCK);
    kp_step(pz, po, pe);
    #1;
    ef = FW'(m_fails);
    chk("outs{Z,O,EN,DR,LK,AL,FC}", {ZBUT, OBUT, ENBL, DOOR, LKOUT, ALRM, FCNT},
        {e_zbut, e_obut, e_enbl, e_door, e_lk, e_alrm, ef});
    n_strobe += int'(ZBUT) + int'(OBUT);
    n_enlow  += int'(!ENBL);
    n_door   += int'(DOOR);
  endtask

  task automatic press(input bit one, input int gap);
    cycle(!one, one, 1'b0, 1'b0);
    repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserted between edges so the clear is seen without any clock edge
  task automatic apply_reset();
    #2 RST = 1'b1;
    ZRAW = 0; ORAW = 0; ACK = 0; KSECV = 0; KRSTO = 0; KULCK = 0;
    #1 chk("async_rst_outs", {ZBUT, OBUT, ENBL, DOOR, LKOUT, ALRM, FCNT}, 0);
    model_reset(); kp_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    model_reset(); kp_reset();
    apply_reset();
    cycle(0, 0, 0, 0);
    chk("enbl_first_edge", ENBL, 1);
    idle(2);

    // correct code 1000, door hold length
    press(1, 2); press(0, 2); press(0, 2); press(0, 0);
    n_door = 0;
    idle(20);
    chk("door_cycles", n_door, OPEN_CYCLES);
    chk("fcnt_after_open", FCNT, 0);

    // three wrong entries, presses dropped during lockout
    press(0, 3); chk("fcnt_1", FCNT, 1);
    press(0, 3); chk("fcnt_2", FCNT, 2);
    n_enlow = 0;
    press(0, 3);
    chk("lkout_set", LKOUT, 1);
    n_strobe = 0;
    for (int i = 0; i < 12; i++) cycle(i % 4 == 0, i % 4 == 2, 0, 0);
    chk("lockout_strobes", n_strobe, 0);
    idle(8);
    chk("lockout_enbl_low", n_enlow, LOCKOUT_CYCLES);
    chk("lockout_exit_fcnt", FCNT, 0);
    chk("lockout_exit_enbl", ENBL, 1);

    // alarm during entry keeps FCNT
    press(0, 3); press(0, 3);
    press(1, 1);
    cycle(0, 0, 0, 1);
    chk("alarm_alrm", ALRM, 1);
    chk("alarm_enbl", ENBL, 0);
    chk("alarm_fcnt", FCNT, 2);
    idle(3);
    cycle(0, 0, 1, 1);
    chk("alarm_ack_with_secv", ALRM, 1);
    cycle(0, 0, 1, 0);
    chk("alarm_cleared", ALRM, 0);
    chk("alarm_exit_enbl", ENBL, 1);
    idle(3);

    // coincident edges, then a long held ORAW
    n_strobe = 0;
    repeat (3) cycle(1, 1, 0, 0);
    idle(3);
    chk("coincident_strobes", n_strobe, 0);
    n_strobe = 0;
    repeat (10) cycle(0, 1, 0, 0);
    idle(3);
    chk("held_obut_strobes", n_strobe, 1);

    // finish the code, then press during the open hold
    press(0, 2); press(0, 2); press(0, 0);
    idle(1);
    n_strobe = 0;
    for (int i = 0; i < 6; i++) cycle(i % 4 == 0, i % 4 == 2, 0, 0);
    chk("open_hold_strobes", n_strobe, 0);
    idle(10);

    // entry inactivity
    press(1, 0);
    n_enlow = 0;
    idle(40);
    chk("timeout_enbl_low", n_enlow, TMO_LOW);
    chk("timeout_fcnt", FCNT, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r_z = ~r_z;
      if ($urandom_range(3) == 0) r_o = ~r_o;
      cycle(r_z, r_o, $urandom_range(3) == 0, $urandom_range(150) == 0);
    end
    idle(2);

    // reset in the middle of a lockout
    apply_reset();
    idle(3);
    press(0, 3); press(0, 3); press(0, 3);
    idle(4);
    chk("pre_rst_lkout", LKOUT, 1);
    apply_reset();
    idle(3);
    chk("post_rst_enbl", ENBL, 1);
    chk("post_rst_lkout", LKOUT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
